// File: rtl/neck_pkg.sv
// Shared definitions for the necking-detection chain.
//   - DIF_GUARD / dif_width(): difference outputs carry three guard bits over
//     the sample width so that d3 (|coeffs| summing to 8) never wraps.
//   - neck_state_t: judge FSM state encodings.
//   - bits_for(): width needed to hold a non-negative count value.
package neck_pkg;

  localparam int DIF_GUARD = 3;

  typedef enum logic [2:0] {
    WARMUP  = 3'd0,
    ARMED   = 3'd1,
    CONFIRM = 3'd2,
    FIRE    = 3'd3,
    BLANK   = 3'd4
  } neck_state_t;

  function automatic int dif_width(input int data_w);
    return data_w + DIF_GUARD;
  endfunction

  // Smallest width (at least 1) able to represent max_val.
  function automatic int bits_for(input int max_val);
    int w;
    w = 1;
    while (w < 31 && (1 << w) <= max_val) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/neck_diff_engine.sv
// History buffer and first/second/third difference stage.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sample_valid      one-cycle strobe qualifying sample_data
//   sample_data       signed filtered sample
//   dif_valid         one-cycle strobe, d1/d2/d3 were just updated
//   d1, d2, d3        signed differences over STRIDE samples (registered)
//   fill_done         history holds the full 3*STRIDE+1 sample window
module neck_diff_engine
  import neck_pkg::*;
#(
  parameter  int DATA_W = 12,
  parameter  int STRIDE = 1,
  localparam int DIF_W  = dif_width(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  output logic                     dif_valid,
  output logic signed [DIF_W-1:0]  d1,
  output logic signed [DIF_W-1:0]  d2,
  output logic signed [DIF_W-1:0]  d3,
  output logic                     fill_done
);

  // Only the 3*STRIDE previous samples are stored; the incoming sample
  // completes the 3*STRIDE+1 window, so differences are formed in the
  // same cycle the sample arrives and registered at the next edge.
  localparam int HIST_LEN = 3 * STRIDE;
  localparam int FILL_MAX = 3 * STRIDE + 1;
  localparam int FILL_W   = bits_for(FILL_MAX);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FILL_MAX);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_MAX - 1);

  logic signed [DATA_W-1:0] hist_reg  [HIST_LEN];
  logic signed [DATA_W-1:0] hist_next [HIST_LEN];
  logic [FILL_W-1:0]        fill_reg;
  logic                     dif_valid_reg;
  logic signed [DIF_W-1:0]  d1_reg, d2_reg, d3_reg;
  logic signed [DIF_W-1:0]  x0, xs, x2s, x3s;
  logic signed [DIF_W-1:0]  d1_next, d2_next, d3_next;
  logic                     emit;

  // hist_reg[k] holds x[n-1-k] relative to the incoming sample x[n].
  generate
    for (genvar gi = 0; gi < HIST_LEN; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign hist_next[gi] = sample_data;
      end else begin : g_body
        assign hist_next[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  assign x0  = {{DIF_GUARD{sample_data[DATA_W-1]}}, sample_data};
  assign xs  = {{DIF_GUARD{hist_reg[STRIDE-1][DATA_W-1]}}, hist_reg[STRIDE-1]};
  assign x2s = {{DIF_GUARD{hist_reg[2*STRIDE-1][DATA_W-1]}}, hist_reg[2*STRIDE-1]};
  assign x3s = {{DIF_GUARD{hist_reg[3*STRIDE-1][DATA_W-1]}}, hist_reg[3*STRIDE-1]};

  // Intermediate terms may wrap, but every final value fits DIF_W, so
  // two's-complement arithmetic still yields the exact result.
  assign d1_next = x0 - xs;
  assign d2_next = x0 - (xs <<< 1) + x2s;
  assign d3_next = x0 - ((xs <<< 1) + xs) + ((x2s <<< 1) + x2s) - x3s;

  // Emit once this sample completes (or extends) a full window.
  assign emit = sample_valid && (fill_reg >= FILL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST_LEN; i++) hist_reg[i] <= '0;
      fill_reg      <= '0;
      dif_valid_reg <= 1'b0;
      d1_reg        <= '0;
      d2_reg        <= '0;
      d3_reg        <= '0;
    end else begin
      dif_valid_reg <= emit;
      if (sample_valid) begin
        hist_reg <= hist_next;
        if (fill_reg != FILL_FULL) fill_reg <= fill_reg + 1'b1;
      end
      if (emit) begin
        d1_reg <= d1_next;
        d2_reg <= d2_next;
        d3_reg <= d3_next;
      end
    end
  end

  assign dif_valid = dif_valid_reg;
  assign d1        = d1_reg;
  assign d2        = d2_reg;
  assign d3        = d3_reg;
  assign fill_done = (fill_reg == FILL_FULL);

endmodule

// File: rtl/neck_detect_core.sv
// Necking detector: difference engine plus a judge FSM that qualifies
// threshold hits over CONFIRM_N consecutive difference samples, drives a
// timed necking output and then blanks the judge for BLANK_SMP samples.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                judge enable (history/differences update regardless)
//   sample_valid      one-cycle strobe for sample_data
//   sample_data       signed filtered sample
//   th1, th2, th3     signed thresholds for d1/d2/d3 (strict greater-than)
//   dif_valid         one-cycle strobe, d1/d2/d3 updated
//   d1, d2, d3        registered differences
//   necking_signal    high for exactly HOLD_CYC cycles per detection
//   neck_pulse        one-cycle pulse on the rising edge of necking_signal
//   busy              high while firing or blanking
module neck_detect_core
  import neck_pkg::*;
#(
  parameter  int DATA_W    = 12,
  parameter  int STRIDE    = 1,
  parameter  int CONFIRM_N = 3,
  parameter  int HOLD_CYC  = 1000,
  parameter  int BLANK_SMP = 64,
  localparam int DIF_W     = dif_width(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  input  logic signed [DIF_W-1:0]  th1,
  input  logic signed [DIF_W-1:0]  th2,
  input  logic signed [DIF_W-1:0]  th3,
  output logic                     dif_valid,
  output logic signed [DIF_W-1:0]  d1,
  output logic signed [DIF_W-1:0]  d2,
  output logic signed [DIF_W-1:0]  d3,
  output logic                     necking_signal,
  output logic                     neck_pulse,
  output logic                     busy
);

  localparam int HOLD_W  = bits_for(HOLD_CYC - 1);
  localparam int BLANK_W = bits_for(BLANK_SMP);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_SMP > 0) ? BLANK_SMP - 1 : 0);
  localparam logic [3:0]         CNT_TARGET = 4'(CONFIRM_N);

  logic        fill_done;
  logic        hit;

  neck_state_t          state_reg, state_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [BLANK_W-1:0]   blank_reg, blank_next;
  logic                 necking_reg, pulse_reg, busy_reg;

  neck_diff_engine #(
    .DATA_W (DATA_W),
    .STRIDE (STRIDE)
  ) u_diff (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .dif_valid    (dif_valid),
    .d1           (d1),
    .d2           (d2),
    .d3           (d3),
    .fill_done    (fill_done)
  );

  assign hit = dif_valid && en && (d1 > th1) && (d2 > th2) && (d3 > th3);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    blank_next = blank_reg;
    case (state_reg)
      // The first valid difference coincides with fill_done, so WARMUP
      // judges that sample as ARMED would rather than dropping it.
      WARMUP, ARMED: begin
        if (state_reg == ARMED || fill_done) begin
          state_next = ARMED;
          cnt_next   = '0;
          if (hit) begin
            cnt_next = 4'd1;
            if (CONFIRM_N == 1) begin
              state_next = FIRE;
              hold_next  = '0;
            end else begin
              state_next = CONFIRM;
            end
          end
        end
      end
      CONFIRM: begin
        if (!en) begin
          cnt_next   = '0;
          state_next = ARMED;
        end else if (dif_valid) begin
          if (hit) begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg + 4'd1 == CNT_TARGET) begin
              state_next = FIRE;
              hold_next  = '0;
            end
          end else begin
            cnt_next   = '0;
            state_next = ARMED;
          end
        end
      end
      FIRE: begin
        if (hold_reg == HOLD_LAST) begin
          cnt_next   = '0;
          blank_next = '0;
          state_next = (BLANK_SMP == 0) ? ARMED : BLANK;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      BLANK: begin
        if (dif_valid) begin
          if (blank_reg == BLANK_LAST) state_next = ARMED;
          else                         blank_next = blank_reg + 1'b1;
        end
      end
      default: state_next = WARMUP;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and carry no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= WARMUP;
      cnt_reg     <= '0;
      hold_reg    <= '0;
      blank_reg   <= '0;
      necking_reg <= 1'b0;
      pulse_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hold_reg    <= hold_next;
      blank_reg   <= blank_next;
      necking_reg <= (state_next == FIRE);
      pulse_reg   <= (state_next == FIRE) && (state_reg != FIRE);
      busy_reg    <= (state_next == FIRE) || (state_next == BLANK);
    end
  end

  assign necking_signal = necking_reg;
  assign neck_pulse     = pulse_reg;
  assign busy           = busy_reg;

endmodule

// File: tb/tb_neck_detect_core.sv
module tb_neck_detect_core;

  localparam int DW = 12;
  localparam int FW = 15;

  typedef struct {
    int d1;
    int d2;
    int d3;
  } dif_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: STRIDE=1, CONFIRM_N=3, HOLD 1000, BLANK 64 (judge tests)
  logic                 rst_a, en_a, sv_a;
  logic signed [DW-1:0] sd_a;
  logic signed [FW-1:0] th1_a, th2_a, th3_a;
  logic                 dv_a, neck_a, pulse_a, busy_a;
  logic signed [FW-1:0] d1_a, d2_a, d3_a;

  // dut_b: STRIDE=2 (difference maths and extremes)
  logic                 rst_b, en_b, sv_b;
  logic signed [DW-1:0] sd_b;
  logic signed [FW-1:0] th1_b, th2_b, th3_b;
  logic                 dv_b, neck_b, pulse_b, busy_b;
  logic signed [FW-1:0] d1_b, d2_b, d3_b;

  neck_detect_core #(
    .DATA_W(12), .STRIDE(1), .CONFIRM_N(3), .HOLD_CYC(1000), .BLANK_SMP(64)
  ) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .sample_valid(sv_a), .sample_data(sd_a),
    .th1(th1_a), .th2(th2_a), .th3(th3_a), .dif_valid(dv_a),
    .d1(d1_a), .d2(d2_a), .d3(d3_a),
    .necking_signal(neck_a), .neck_pulse(pulse_a), .busy(busy_a)
  );

  neck_detect_core #(
    .DATA_W(12), .STRIDE(2), .CONFIRM_N(1), .HOLD_CYC(5), .BLANK_SMP(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .sample_valid(sv_b), .sample_data(sd_b),
    .th1(th1_b), .th2(th2_b), .th3(th3_b), .dif_valid(dv_b),
    .d1(d1_b), .d2(d2_b), .d3(d3_b),
    .necking_signal(neck_b), .neck_pulse(pulse_b), .busy(busy_b)
  );

  int   checks = 0;
  int   errors = 0;
  dif_t exp_a[$];
  dif_t exp_b[$];
  int   fire_a[$];
  int   hist_a[$];
  int   last_t_a = 0;
  bit   hold_abort = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin
    dif_t e;
    int   run;
    run = 0;
    forever begin
      @(negedge clk);
      if (dv_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL dif_a_unexpected: cyc %0d got d=(%0d,%0d,%0d) required no strobe",
                   cyc, d1_a, d2_a, d3_a);
        end else begin
          e = exp_a.pop_front();
          if (d1_a !== e.d1 || d2_a !== e.d2 || d3_a !== e.d3) begin
            errors++;
            $display("FAIL dif_a: cyc %0d got d=(%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     cyc, d1_a, d2_a, d3_a, e.d1, e.d2, e.d3);
          end else begin
            $display("dif_a cyc %0d d=(%0d,%0d,%0d) ok", cyc, d1_a, d2_a, d3_a);
          end
        end
      end
      if (pulse_a) begin
        checks++;
        if (fire_a.size() == 0) begin
          errors++;
          $display("FAIL pulse_a_unexpected: got pulse at cyc %0d required none", cyc);
        end else begin
          int t;
          t = fire_a.pop_front();
          if (cyc != t) begin
            errors++;
            $display("FAIL pulse_a: got cyc %0d required cyc %0d", cyc, t);
          end else begin
            $display("pulse_a cyc %0d ok", cyc);
          end
        end
      end
      if (neck_a) begin
        run++;
      end else if (run > 0) begin
        if (!hold_abort) chk("hold_width_a", run, 1000);
        hold_abort = 1'b0;
        run = 0;
      end
    end
  end

  initial begin
    dif_t e;
    forever begin
      @(negedge clk);
      if (dv_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL dif_b_unexpected: cyc %0d got d=(%0d,%0d,%0d) required no strobe",
                   cyc, d1_b, d2_b, d3_b);
        end else begin
          e = exp_b.pop_front();
          if (d1_b !== e.d1 || d2_b !== e.d2 || d3_b !== e.d3) begin
            errors++;
            $display("FAIL dif_b: cyc %0d got d=(%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     cyc, d1_b, d2_b, d3_b, e.d1, e.d2, e.d3);
          end else begin
            $display("dif_b cyc %0d d=(%0d,%0d,%0d) ok", cyc, d1_b, d2_b, d3_b);
          end
        end
      end
      if (neck_b || pulse_b || busy_b) begin
        checks++;
        errors++;
        $display("FAIL judge_b_idle: got neck=%0b pulse=%0b busy=%0b required 0",
                 neck_b, pulse_b, busy_b);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Expected differences for dut_a from the arithmetic definition (stride 1).
  task automatic model_a(input int x);
    dif_t e;
    hist_a.push_front(x);
    if (hist_a.size() > 4) void'(hist_a.pop_back());
    if (hist_a.size() == 4) begin
      e.d1 = hist_a[0] - hist_a[1];
      e.d2 = hist_a[0] - 2*hist_a[1] + hist_a[2];
      e.d3 = hist_a[0] - 3*hist_a[1] + 3*hist_a[2] - hist_a[3];
      exp_a.push_back(e);
    end
  endtask

  task automatic send_a(input int x);
    @(posedge clk); #1;
    sv_a = 1'b1;
    sd_a = DW'(x);
    last_t_a = cyc;
    model_a(x);
  endtask

  task automatic end_a();
    @(posedge clk); #1;
    sv_a = 1'b0;
  endtask

  // One sample followed by an idle cycle; thresholds change in the cycle
  // the judge evaluates this sample.
  task automatic slow_a(input int x, input int t1, input int t2, input int t3);
    send_a(x);
    @(posedge clk); #1;
    sv_a  = 1'b0;
    th1_a = FW'(t1);
    th2_a = FW'(t2);
    th3_a = FW'(t3);
  endtask

  task automatic expect_fire_a();
    fire_a.push_back(last_t_a + 2);
  endtask

  task automatic send_b(input int x);
    @(posedge clk); #1;
    sv_b = 1'b1;
    sd_b = DW'(x);
  endtask

  task automatic push_b(input int a, input int b, input int c);
    dif_t e;
    e.d1 = a; e.d2 = b; e.d3 = c;
    exp_b.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_a = 1'b1; en_a = 1'b1; sv_a = 1'b0; sd_a = '0;
    th1_a = 15'sd0; th2_a = 15'sd0; th3_a = -15'sd1;
    rst_b = 1'b1; en_b = 1'b0; sv_b = 1'b0; sd_b = '0;
    th1_b = 15'sd16383; th2_b = 15'sd16383; th3_b = 15'sd16383;
    wait_cyc(3);
    chk("reset_a_outputs", {dv_a, neck_a, pulse_a, busy_a}, 0);
    chk("reset_a_d", int'(d1_a) | int'(d2_a) | int'(d3_a), 0);
    chk("reset_b_outputs", {dv_b, neck_b, pulse_b, busy_b}, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // dut_b: x=n^2 at stride 2, only the 7th sample fills the window
    for (int n = 0; n < 7; n++) send_b(n*n);
    push_b(20, 8, 0);
    @(posedge clk); #1; sv_b = 1'b0;
    wait_cyc(4);
    rst_b = 1'b1;
    wait_cyc(1);
    chk("reset_b_mid_d1", int'(d1_b), 0);
    rst_b = 1'b0;
    // extremes, back-to-back
    send_b(-2048); send_b(-2048); send_b(2047); send_b(2047);
    send_b(-2048); send_b(-2048);
    send_b(2047);  push_b(4095, 8190, 16380);
    send_b(2047);  push_b(4095, 8190, 16380);
    send_b(-2048); push_b(-4095, -8190, -16380);
    @(posedge clk); #1; sv_b = 1'b0;
    wait_cyc(4);

    // dut_a: cubic ramp, warm-up then fire on the 3rd qualifying sample (n=5)
    for (int n = 0; n <= 12; n++) begin
      send_a(n*n*n);
      if (n == 5) expect_fire_a();
    end
    end_a();
    wait_cyc(500);
    chk("busy_in_fire", busy_a, 1);
    chk("neck_in_fire", neck_a, 1);
    wait_cyc(520);
    chk("neck_after_hold", neck_a, 0);
    chk("busy_in_blank", busy_a, 1);

    // blanking: 64 strobes ignored, refire needs 3 hits after that
    for (int i = 1; i <= 67; i++) begin
      slow_a(1728, -1, -1, -1);
      if (i == 65) chk("busy_armed_after_blank", busy_a, 0);
      if (i == 67) expect_fire_a();
    end
    wait_cyc(1020);

    // confirm break: hit,hit,miss,hit,hit,hit
    for (int i = 0; i < 64; i++) slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    slow_a(1728, 0, 0, 0);
    slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    expect_fire_a();
    wait_cyc(1020);
    for (int i = 0; i < 64; i++) slow_a(1728, -1, -1, -1);

    // en low during CONFIRM clears the count
    slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    @(posedge clk); #1; en_a = 1'b0;
    @(posedge clk); #1; en_a = 1'b1;
    slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    slow_a(1728, -1, -1, -1);
    expect_fire_a();

    // reset mid-fire
    wait_cyc(20);
    chk("neck_before_rst", neck_a, 1);
    hold_abort = 1'b1;
    rst_a = 1'b1;
    wait_cyc(1);
    chk("neck_after_rst", neck_a, 0);
    chk("busy_after_rst", busy_a, 0);
    rst_a = 1'b0;
    hist_a.delete();
    th1_a = 15'sd16383; th2_a = 15'sd16383; th3_a = 15'sd16383;
    send_a(10); send_a(20); send_a(30);
    end_a();
    wait_cyc(5);
    send_a(40);
    end_a();
    wait_cyc(10);

    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);
    chk("fire_a_drained", fire_a.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
